// File: rtl/exfsm.sv
// Execute-stage control FSM: decodes the latched IR and sequences datapath/memory strobes for one instruction.
// Starts on a falling edge of IFactive; NOP/JMP 3 cycles, ADD 6, ST 6+W, LD 7+W, with W the MFC wait cycles.
module exfsm #(
  parameter int IR_WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                IFactive,
  input  logic [IR_WIDTH-1:0] IR,
  input  logic                MFC,
  output logic                IRaddrOut,
  output logic                PCin,
  output logic                PCinc,
  output logic                MARin,
  output logic                memEN,
  output logic                RW,
  output logic                MDRreadEN,
  output logic                MDRwriteEN,
  output logic                MDRout,
  output logic                RegOutEN,
  output logic                RegInEN,
  output logic [1:0]          regSel,
  output logic                ALUAin,
  output logic                ALUBin,
  output logic                ALUout,
  output logic                done,
  output logic                active,
  output logic                illegal
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_DECODE = 4'd1,
    S_ADDR   = 4'd2,
    S_RD     = 4'd3,
    S_LATCH  = 4'd4,
    S_WB     = 4'd5,
    S_SRC    = 4'd6,
    S_WR     = 4'd7,
    S_ALUA   = 4'd8,
    S_ALUB   = 4'd9,
    S_ALUW   = 4'd10,
    S_JMP    = 4'd11,
    S_PCINC  = 4'd12,
    S_DONE   = 4'd13
  } state_t;

  localparam logic [3:0] OP_LD  = 4'd1;
  localparam logic [3:0] OP_ST  = 4'd2;
  localparam logic [3:0] OP_ADD = 4'd3;
  localparam logic [3:0] OP_JMP = 4'd4;

  state_t     r_state;
  state_t     w_next;
  logic       r_if_prev;
  logic [3:0] r_op;
  logic [1:0] r_rd;
  logic [1:0] r_rs;
  logic       r_illegal;
  logic       w_start;
  logic       w_unused_ir;

  // The addr field is consumed by the datapath directly, never by the FSM.
  assign w_unused_ir = ^IR;
  assign w_start     = (r_state == S_IDLE) && !IFactive && r_if_prev;
  assign illegal     = r_illegal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_if_prev <= 1'b0;
      r_op      <= 4'd0;
      r_rd      <= 2'd0;
      r_rs      <= 2'd0;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_if_prev <= IFactive;
      if (w_start) begin
        r_op <= IR[15:12];
        r_rd <= IR[11:10];
        r_rs <= IR[9:8];
      end
      if ((r_state == S_DECODE) && (r_op > OP_JMP)) begin
        r_illegal <= 1'b1;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = w_start ? S_DECODE : S_IDLE;
      S_DECODE: begin
        case (r_op)
          OP_LD, OP_ST: w_next = S_ADDR;
          OP_ADD:       w_next = S_ALUA;
          OP_JMP:       w_next = S_JMP;
          default:      w_next = S_PCINC;
        endcase
      end
      S_ADDR:   w_next = (r_op == OP_ST) ? S_SRC : S_RD;
      S_RD:     w_next = MFC ? S_LATCH : S_RD;
      S_LATCH:  w_next = S_WB;
      S_WB:     w_next = S_PCINC;
      S_SRC:    w_next = S_WR;
      S_WR:     w_next = MFC ? S_PCINC : S_WR;
      S_ALUA:   w_next = S_ALUB;
      S_ALUB:   w_next = S_ALUW;
      S_ALUW:   w_next = S_PCINC;
      S_JMP:    w_next = S_DONE;
      S_PCINC:  w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    IRaddrOut  = 1'b0;
    PCin       = 1'b0;
    PCinc      = 1'b0;
    MARin      = 1'b0;
    memEN      = 1'b0;
    RW         = 1'b0;
    MDRreadEN  = 1'b0;
    MDRwriteEN = 1'b0;
    MDRout     = 1'b0;
    RegOutEN   = 1'b0;
    RegInEN    = 1'b0;
    regSel     = 2'd0;
    ALUAin     = 1'b0;
    ALUBin     = 1'b0;
    ALUout     = 1'b0;
    done       = 1'b0;
    active     = 1'b1;
    case (r_state)
      S_IDLE:   active = 1'b0;
      S_DECODE: ;
      S_ADDR:   begin IRaddrOut = 1'b1; MARin = 1'b1; end
      S_RD:     begin memEN = 1'b1; RW = 1'b1; end
      S_LATCH:  begin memEN = 1'b1; RW = 1'b1; MDRreadEN = 1'b1; end
      S_WB:     begin MDRout = 1'b1; RegInEN = 1'b1; regSel = r_rd; end
      S_SRC:    begin RegOutEN = 1'b1; MDRwriteEN = 1'b1; regSel = r_rs; end
      S_WR:     memEN = 1'b1;
      S_ALUA:   begin RegOutEN = 1'b1; ALUAin = 1'b1; regSel = r_rd; end
      S_ALUB:   begin RegOutEN = 1'b1; ALUBin = 1'b1; regSel = r_rs; end
      S_ALUW:   begin ALUout = 1'b1; RegInEN = 1'b1; regSel = r_rd; end
      S_JMP:    begin IRaddrOut = 1'b1; PCin = 1'b1; end
      S_PCINC:  PCinc = 1'b1;
      S_DONE:   done = 1'b1;
      default:  active = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_exfsm.sv
// Randomized bench for exfsm: per-cycle strobe patterns and latency compared against a queue-based instruction model.
module tb_exfsm;

  logic        clk;
  logic        rst;
  logic        IFactive;
  logic [15:0] IR;
  logic        MFC;
  logic        IRaddrOut, PCin, PCinc, MARin, memEN, RW, MDRreadEN, MDRwriteEN;
  logic        MDRout, RegOutEN, RegInEN, ALUAin, ALUBin, ALUout, done, active, illegal;
  logic [1:0]  regSel;

  exfsm #(.IR_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .IFactive(IFactive), .IR(IR), .MFC(MFC),
    .IRaddrOut(IRaddrOut), .PCin(PCin), .PCinc(PCinc), .MARin(MARin),
    .memEN(memEN), .RW(RW), .MDRreadEN(MDRreadEN), .MDRwriteEN(MDRwriteEN),
    .MDRout(MDRout), .RegOutEN(RegOutEN), .RegInEN(RegInEN), .regSel(regSel),
    .ALUAin(ALUAin), .ALUBin(ALUBin), .ALUout(ALUout), .done(done),
    .active(active), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [17:0] outs = {IRaddrOut, PCin, PCinc, MARin, memEN, RW, MDRreadEN, MDRwriteEN,
                      MDRout, RegOutEN, RegInEN, regSel, ALUAin, ALUBin, ALUout, done, active};

  localparam logic [17:0] O_IRADDR = 18'h20000;
  localparam logic [17:0] O_PCIN   = 18'h10000;
  localparam logic [17:0] O_PCINC  = 18'h08000;
  localparam logic [17:0] O_MARIN  = 18'h04000;
  localparam logic [17:0] O_MEMEN  = 18'h02000;
  localparam logic [17:0] O_RW     = 18'h01000;
  localparam logic [17:0] O_MDRRD  = 18'h00800;
  localparam logic [17:0] O_MDRWR  = 18'h00400;
  localparam logic [17:0] O_MDROUT = 18'h00200;
  localparam logic [17:0] O_REGOUT = 18'h00100;
  localparam logic [17:0] O_REGIN  = 18'h00080;
  localparam logic [17:0] O_ALUA   = 18'h00010;
  localparam logic [17:0] O_ALUB   = 18'h00008;
  localparam logic [17:0] O_ALUOUT = 18'h00004;
  localparam logic [17:0] O_DONE   = 18'h00002;
  localparam logic [17:0] O_ACTIVE = 18'h00001;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  bit model_ill = 1'b0;

  logic [17:0] exp_q[$];
  bit          mfc_q[$];

  function automatic logic [17:0] sel(input logic [1:0] r);
    return {11'd0, r, 5'd0};
  endfunction

  function automatic int exp_latency(input logic [3:0] op, input int w);
    case (op)
      4'd1:    return 7 + w;
      4'd2:    return 6 + w;
      4'd3:    return 6;
      default: return 3;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, expv, $time);
    end
  endtask

  // Expected strobe word for every cycle of one instruction, plus the MFC value to drive in each.
  task automatic build(input logic [15:0] ir, input int w);
    logic [3:0] op;
    logic [1:0] rd, rs;
    int m;
    op = ir[15:12];
    rd = ir[11:10];
    rs = ir[9:8];
    exp_q.delete();
    mfc_q.delete();
    exp_q.push_back(O_ACTIVE);
    case (op)
      4'd1: begin
        exp_q.push_back(O_ACTIVE | O_IRADDR | O_MARIN);
        repeat (w + 1) exp_q.push_back(O_ACTIVE | O_MEMEN | O_RW);
        exp_q.push_back(O_ACTIVE | O_MEMEN | O_RW | O_MDRRD);
        exp_q.push_back(O_ACTIVE | O_MDROUT | O_REGIN | sel(rd));
        exp_q.push_back(O_ACTIVE | O_PCINC);
      end
      4'd2: begin
        exp_q.push_back(O_ACTIVE | O_IRADDR | O_MARIN);
        exp_q.push_back(O_ACTIVE | O_REGOUT | O_MDRWR | sel(rs));
        repeat (w + 1) exp_q.push_back(O_ACTIVE | O_MEMEN);
        exp_q.push_back(O_ACTIVE | O_PCINC);
      end
      4'd3: begin
        exp_q.push_back(O_ACTIVE | O_REGOUT | O_ALUA | sel(rd));
        exp_q.push_back(O_ACTIVE | O_REGOUT | O_ALUB | sel(rs));
        exp_q.push_back(O_ACTIVE | O_ALUOUT | O_REGIN | sel(rd));
        exp_q.push_back(O_ACTIVE | O_PCINC);
      end
      4'd4: exp_q.push_back(O_ACTIVE | O_IRADDR | O_PCIN);
      default: exp_q.push_back(O_ACTIVE | O_PCINC);
    endcase
    exp_q.push_back(O_ACTIVE | O_DONE);
    for (int i = 0; i < exp_q.size(); i++) mfc_q.push_back(1'($urandom_range(0, 1)));
    if (op == 4'd1 || op == 4'd2) begin
      m = (op == 4'd1) ? 2 : 3;
      for (int k = 0; k < w; k++) mfc_q[m + k] = 1'b0;
      mfc_q[m + w] = 1'b1;
    end
  endtask

  task automatic run_instr(input logic [15:0] ir, input int w, input bit pulse, input int abort_idx);
    bit is_ill;
    int lat;
    build(ir, w);
    is_ill = (ir[15:12] > 4'd4);
    lat = 0;
    @(negedge clk);
    IR = ir;
    IFactive = 1'b1;
    MFC = 1'($urandom_range(0, 1));
    repeat ($urandom_range(1, 3)) begin
      @(negedge clk);
      check("idle_pre", {14'd0, illegal, outs}, {14'd0, model_ill, 18'd0});
    end
    IFactive = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      check("strobes", {14'd0, outs}, {14'd0, exp_q[i]});
      check("illegal", {31'd0, illegal}, {31'd0, (i == 0) ? model_ill : (model_ill | is_ill)});
      if (done && lat == 0) lat = i + 1;
      MFC = mfc_q[i];
      if (pulse && i == 1) IFactive = 1'b1;
      if (pulse && i == 2) IFactive = 1'b0;
      if (i == abort_idx) begin
        #1 rst = 1'b1;
        #1 check("rst_async", {14'd0, illegal, outs}, 32'd0);
        @(negedge clk);
        check("rst_hold", {14'd0, illegal, outs}, 32'd0);
        rst = 1'b0;
        model_ill = 1'b0;
        repeat (2) begin
          @(negedge clk);
          check("rst_after", {14'd0, illegal, outs}, 32'd0);
        end
        return;
      end
    end
    model_ill = model_ill | is_ill;
    check("latency", lat, exp_latency(ir[15:12], w));
    repeat (2) begin
      @(negedge clk);
      check("idle_post", {14'd0, illegal, outs}, {14'd0, model_ill, 18'd0});
    end
  endtask

  initial begin
    logic [15:0] rir;
    int sel_op;
    rst = 1'b1;
    IFactive = 1'b0;
    IR = 16'h0000;
    MFC = 1'b0;
    #1 check("reset_outs", {14'd0, illegal, outs}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_release", {14'd0, illegal, outs}, 32'd0);

    run_instr(16'h1A05, 2, 1'b0, -1);
    run_instr(16'h2703, 0, 1'b0, -1);
    run_instr(16'h3600, 0, 1'b0, -1);
    run_instr(16'h40F0, 0, 1'b1, -1);
    run_instr(16'hF000, 0, 1'b0, -1);
    // IFactive stays low: no re-trigger of the illegal instruction.
    repeat (8) begin
      @(negedge clk);
      check("no_retrigger", {14'd0, illegal, outs}, {14'd0, model_ill, 18'd0});
    end

    for (int n = 0; n < 40; n++) begin
      rir = 16'($urandom);
      sel_op = $urandom_range(0, 6);
      rir[15:12] = (sel_op == 6) ? 4'($urandom_range(5, 15)) : 4'(sel_op);
      run_instr(rir, $urandom_range(0, 4), 1'($urandom_range(0, 1)), -1);
    end

    run_instr(16'h1A05, 4, 1'b0, 3);
    run_instr(16'h0000, 0, 1'b0, -1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/exfsm.md
# exfsm

Execute-stage control FSM for the microcontroller datapath. It sits directly downstream of the instruction-fetch FSM. It starts when fetch drops its `active` output, decodes the latched IR, and drives the datapath and memory control strobes for one instruction. It then pulses `done` back to the fetch FSM to start the next fetch.

## Interface
Parameters:
- `IR_WIDTH`, 16: instruction width. Fields: opcode `[15:12]`, rd `[11:10]`, rs `[9:8]`, addr `[7:0]`.

Ports:
- `clk` input 1: single clock. All state changes occur on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `IFactive` input 1: `active` output of the fetch FSM.
- `IR` input IR_WIDTH: instruction register contents. Stable while fetch is idle.
- `MFC` input 1: memory function complete.
- `IRaddrOut` output 1: drive IR addr field onto the bus.
- `PCin` output 1: load PC from the bus.
- `PCinc` output 1: increment PC.
- `MARin` output 1: load MAR from the bus.
- `memEN` output 1: memory enable.
- `RW` output 1: 1 = read, 0 = write.
- `MDRreadEN` output 1: load MDR from memory.
- `MDRwriteEN` output 1: load MDR from the bus.
- `MDRout` output 1: drive MDR onto the bus.
- `RegOutEN` output 1: selected register drives the bus.
- `RegInEN` output 1: selected register loads from the bus.
- `regSel` output 2: register select.
- `ALUAin` output 1: load ALU operand A.
- `ALUBin` output 1: load ALU operand B.
- `ALUout` output 1: drive ALU sum onto the bus.
- `done` output 1: one-cycle pulse that restarts fetch.
- `active` output 1: high in every state except IDLE.
- `illegal` output 1: sticky flag, set on an undefined opcode.

## Operation
- Opcodes:
  - 0 NOP
  - 1 LD rd,[addr]
  - 2 ST rs,[addr]
  - 3 ADD rd,rs (rd ← rd+rs, 16-bit wrap, no carry out)
  - 4 JMP addr
  - 5–15 illegal, executed as NOP.
- States, with Moore outputs. Any output not listed is 0.
  - IDLE: all outputs 0.
  - DECODE: `active` only. Registers opcode/rd/rs from `IR`.
  - ADDR: `IRaddrOut`, `MARin`.
  - RD: `memEN`, `RW`. Holds until `MFC`=1.
  - LATCH: `memEN`, `RW`, `MDRreadEN`.
  - WB: `MDRout`, `RegInEN`, `regSel`=rd.
  - SRC: `RegOutEN`, `MDRwriteEN`, `regSel`=rs.
  - WR: `memEN`, `RW`=0. Holds until `MFC`=1.
  - ALUA: `RegOutEN`, `ALUAin`, `regSel`=rd.
  - ALUB: `RegOutEN`, `ALUBin`, `regSel`=rs.
  - ALUW: `ALUout`, `RegInEN`, `regSel`=rd.
  - JMP: `IRaddrOut`, `PCin`.
  - PCINC: `PCinc`.
  - DONE: `done`.
  - `active`=1 in all states except IDLE. `RW` is 0 in every state except RD and LATCH.
- Start condition: a registered `ifPrev` samples `IFactive` every cycle. IDLE→DECODE when `IFactive`=0 and `ifPrev`=1 (falling edge). A steady-low `IFactive` never re-triggers.
- Transitions out of DECODE:
  - LD → ADDR → RD → LATCH → WB → PCINC
  - ST → ADDR → SRC → WR → PCINC
  - ADD → ALUA → ALUB → ALUW → PCINC
  - JMP → JMP → DONE (no PC increment)
  - NOP → PCINC
  - illegal → PCINC, and sets `illegal`.
- PCINC → DONE → IDLE.
- `illegal` clears only on `rst`.
- `MFC` is ignored outside RD and WR.
- Unencoded state values go to IDLE.

## Timing
- Reset: state=IDLE, `ifPrev`=0, `illegal`=0. All outputs 0 immediately (asynchronous). Reset mid-instruction aborts with no further strobes.
- Outputs are pure functions of registered state (plus registered rd/rs for `regSel`). They are glitch-free relative to `clk`.
- Latency is counted from the first edge that samples the `IFactive` fall to the `done` cycle, inclusive:
  - NOP: 3 cycles.
  - JMP: 3 cycles.
  - ADD: 6 cycles.
  - LD: 7+W cycles.
  - ST: 6+W cycles.
  - W = number of extra cycles `MFC` stays low in RD/WR (W=0 when `MFC` is already high on entry).
- `done` is high for exactly one cycle. The next instruction requires `IFactive` to rise and then fall again.
- If `IFactive` rises while the FSM is not in IDLE, it is ignored; the instruction completes.

## Test plan
- Reset while in RD: all outputs 0 at once. After release, state is IDLE and `illegal`=0.
- `IR`=0x1A05 (LD r2,[5]), `MFC` high 2 cycles after RD entry: 9-cycle sequence. `RW`=1 in RD and LATCH. WB has `regSel`=2. `done` pulses once.
- `IR`=0x2703 (ST r3,[3]) with immediate `MFC`: SRC `regSel`=3. WR has `memEN`=1, `RW`=0. 6 cycles to `done`.
- `IR`=0x3600 (ADD r1,r2): ALUA `regSel`=1, ALUB `regSel`=2, ALUW `RegInEN` with `regSel`=1. `PCinc` exactly once.
- `IR`=0x40F0 (JMP 0xF0): `PCin`+`IRaddrOut` for one cycle. `PCinc` never asserted. `done` in the 3rd cycle.
- `IR`=0xF000, then `IFactive` held low after `done`: `illegal` latches 1. No second execution without an `IFactive` rise then fall.
